alu_input_sequencer: RTL

Sequential front end that loads the ALU's two operands and opcode one after another from a shared switch bus, advancing on a debounced pushbutton. After the third press it latches the ALU output into a result register and flags it valid. It sits between the board I/O (switches, button, LEDs) and the combinational ALU, and acts as the initiator that drives `dato_a`, `dato_b` and `opcode`.

---
 rtl/alu_input_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_input_sequencer.sv
// Loads ALU operand A, operand B and opcode from a shared switch bus on
// successive debounced button presses, then latches the ALU result.
module alu_input_sequencer #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned NB_OP           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NB_DATA-1:0] sw_data,
    input  logic               btn_load,
    input  logic [NB_DATA-1:0] alu_out,
    output logic [NB_DATA-1:0] dato_a,
    output logic [NB_DATA-1:0] dato_b,
    output logic [NB_OP-1:0]   opcode,
    output logic [NB_DATA-1:0] result,
    output logic               result_valid,
    output logic [1:0]         state
);

    // Counter only needs to hold 0 .. DEBOUNCE_CYCLES-1
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_EXEC = 2'b11
    } state_t;

    logic             s_meta;
    logic             s;
    logic             d;
    logic             d_q;
    logic [CNT_W-1:0] cnt;
    logic             load_pulse;

    state_t             state_q;
    state_t             state_d;
    logic [NB_DATA-1:0] dato_a_d;
    logic [NB_DATA-1:0] dato_b_d;
    logic [NB_OP-1:0]   opcode_d;
    logic [NB_DATA-1:0] result_d;
    logic               result_valid_d;

    // Two-flop synchronizer for the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
        end else begin
            s_meta <= btn_load;
            s      <= s_meta;
        end
    end

    // Debouncer: accept a level change only after it has been stable long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d   <= 1'b0;
            d_q <= 1'b0;
            cnt <= '0;
        end else begin
            d_q <= d;
            if (s != d) begin
                if (cnt == CNT_LAST) begin
                    d   <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign load_pulse = d & ~d_q;

    // State and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_A;
            dato_a       <= '0;
            dato_b       <= '0;
            opcode       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            dato_a       <= dato_a_d;
            dato_b       <= dato_b_d;
            opcode       <= opcode_d;
            result       <= result_d;
            result_valid <= result_valid_d;
        end
    end

    // Next-state and capture decisions; everything holds by default
    always_comb begin
        state_d        = state_q;
        dato_a_d       = dato_a;
        dato_b_d       = dato_b;
        opcode_d       = opcode;
        result_d       = result;
        result_valid_d = result_valid;
        case (state_q)
            S_A: begin
                if (load_pulse) begin
                    dato_a_d       = sw_data;
                    result_valid_d = 1'b0;
                    state_d        = S_B;
                end
            end
            S_B: begin
                if (load_pulse) begin
                    dato_b_d = sw_data;
                    state_d  = S_OP;
                end
            end
            S_OP: begin
                if (load_pulse) begin
                    opcode_d = sw_data[NB_OP-1:0];
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d       = alu_out;
                result_valid_d = 1'b1;
                state_d        = S_A;
            end
            default: state_d = S_A;
        endcase
    end

    assign state = state_q;

endmodule
